alu_writeback: RTL and testbench

Result writeback stage on the consuming side of the ALU's 64-bit result bus. It accepts one ALU result per handshake together with the op code and destination register, and buffers results in a small in-order queue. It retires one entry per cycle into the register file, the HI/LO pair, the PC or the memory-address port. It also implements mfhi/mflo and sticky halt.

---
 rtl/alu_writeback.sv | 153 +++++++++++++++
 tb/tb_alu_writeback.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage: queues ALU results in order and retires one per cycle into RF, HI/LO, PC or memory address.
// Define WB_TRACE_EN for a simulation-only retire trace; RTL behaviour is the same either way.
module alu_writeback #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_ctrl,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [63:0]           in_result,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  pc_we,
  output logic [31:0]           pc_wdata,
  output logic                  mem_req,
  output logic                  mem_store,
  output logic [31:0]           mem_addr,
  output logic [31:0]           hi,
  output logic [31:0]           lo,
  output logic                  halted,
  output logic                  err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 5 + REG_ADDR_W + 64;

  logic [ENT_W-1:0]      q_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;
  logic [4:0]            head_ctrl;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [63:0]           head_result;
  logic                  do_rf, do_hilo, do_mem, do_pc, do_halt, do_err;
  logic [31:0]           rf_data_nxt;

  assign in_ready = (count < CNT_W'(DEPTH)) && !halted;
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0);
  assign {head_ctrl, head_dest, head_result} = q_mem[rd_ptr];

  // mfhi/mflo read the registered HI/LO, so a mul retired one edge earlier is already visible
  always_comb begin
    do_rf       = 1'b0;
    do_hilo     = 1'b0;
    do_mem      = 1'b0;
    do_pc       = 1'b0;
    do_halt     = 1'b0;
    do_err      = 1'b0;
    rf_data_nxt = head_result[31:0];
    case (head_ctrl) inside
      5'd1, [5'd3:5'd14], 5'd17, 5'd18: do_rf = 1'b1;
      5'd15, 5'd16:                     do_hilo = 1'b1;
      5'd24: begin
        do_rf       = 1'b1;
        rf_data_nxt = hi;
      end
      5'd25: begin
        do_rf       = 1'b1;
        rf_data_nxt = lo;
      end
      5'd0, 5'd2:                       do_mem = 1'b1;
      [5'd19:5'd21]:                    do_pc = 1'b1;
      5'd27:                            do_halt = 1'b1;
      [5'd28:5'd31]:                    do_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      pc_we     <= 1'b0;
      pc_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_store <= 1'b0;
      mem_addr  <= '0;
      hi        <= '0;
      lo        <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      pc_we   <= 1'b0;
      mem_req <= 1'b0;
      err     <= 1'b0;
      if (push) begin
        q_mem[wr_ptr] <= {in_ctrl, in_dest, in_result};
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_rf) begin
          rf_we    <= 1'b1;
          rf_waddr <= head_dest;
          rf_wdata <= rf_data_nxt;
        end
        if (do_hilo) begin
          hi <= head_result[63:32];
          lo <= head_result[31:0];
        end
        if (do_mem) begin
          mem_req   <= 1'b1;
          mem_store <= (head_ctrl == 5'd2);
          mem_addr  <= head_result[31:0];
        end
        if (do_pc) begin
          pc_we    <= 1'b1;
          pc_wdata <= head_result[31:0];
        end
        err <= do_err;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      // halt discards everything still queued, including a push on this same edge
      if (pop && do_halt) begin
        halted <= 1'b1;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (clr && pop) begin
      if (do_halt)
        $display("%0t [WB] HALT", $time);
      else if (do_err)
        $display("%0t [WB] Error: illegal op", $time);
      else if (do_rf)
        $display("%0t [WB] %0d %0d %h", $time, head_ctrl, head_dest, rf_data_nxt);
      else
        $display("%0t [WB] %0d %0d %h", $time, head_ctrl, head_dest, head_result);
    end
  end
`else
  // trace disabled: no simulation output
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int VW    = 1 + AW + 32 + 1 + 32 + 1 + 1 + 32 + 32 + 32 + 1 + 1;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [4:0]    in_ctrl = '0;
  logic [AW-1:0] in_dest = '0;
  logic [63:0]   in_result = '0;
  logic          in_ready, rf_we, pc_we, mem_req, mem_store, halted, err;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata, pc_wdata, mem_addr, hi, lo;

  always #5 clk = ~clk;

  alu_writeback #(.DEPTH(DEPTH), .REG_ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_dest(in_dest), .in_result(in_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .mem_req(mem_req),
    .mem_store(mem_store), .mem_addr(mem_addr), .hi(hi), .lo(lo),
    .halted(halted), .err(err)
  );

  typedef struct packed {
    logic [4:0]    ctrl;
    logic [AW-1:0] dest;
    logic [63:0]   res;
  } ent_t;

  ent_t          mq[$];
  logic          e_rf_we, e_pc_we, e_mem_req, e_mem_store, e_halted, e_err;
  logic [AW-1:0] e_rf_waddr;
  logic [31:0]   e_rf_wdata, e_pc_wdata, e_mem_addr, e_hi, e_lo;
  int            checks = 0;
  int            errors = 0;

  logic [VW-1:0] dut_vec, exp_vec;
  assign dut_vec = {rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, mem_req, mem_store,
                    mem_addr, hi, lo, halted, err};
  assign exp_vec = {e_rf_we, e_rf_waddr, e_rf_wdata, e_pc_we, e_pc_wdata, e_mem_req,
                    e_mem_store, e_mem_addr, e_hi, e_lo, e_halted, e_err};

  function automatic bit model_ready();
    return (mq.size() < DEPTH) && !e_halted;
  endfunction

  task automatic model_reset();
    mq.delete();
    {e_rf_we, e_pc_we, e_mem_req, e_mem_store, e_halted, e_err} = '0;
    e_rf_waddr = '0;
    {e_rf_wdata, e_pc_wdata, e_mem_addr, e_hi, e_lo} = '0;
  endtask

  // Model: retire the oldest entry by op-code rule, accept the offered one, then clock the DUT.
  task automatic tick();
    ent_t e;
    bit   acc;
    bit   flush;
    acc = in_valid && model_ready();
    flush = 0;
    e_rf_we = 0; e_pc_we = 0; e_mem_req = 0; e_err = 0;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.ctrl == 1 || (e.ctrl >= 3 && e.ctrl <= 14) || e.ctrl == 17 || e.ctrl == 18) begin
        e_rf_we = 1; e_rf_waddr = e.dest; e_rf_wdata = e.res[31:0];
      end else if (e.ctrl == 15 || e.ctrl == 16) begin
        e_hi = e.res[63:32]; e_lo = e.res[31:0];
      end else if (e.ctrl == 24 || e.ctrl == 25) begin
        e_rf_we = 1; e_rf_waddr = e.dest; e_rf_wdata = (e.ctrl == 24) ? e_hi : e_lo;
      end else if (e.ctrl == 0 || e.ctrl == 2) begin
        e_mem_req = 1; e_mem_store = (e.ctrl == 2); e_mem_addr = e.res[31:0];
      end else if (e.ctrl >= 19 && e.ctrl <= 21) begin
        e_pc_we = 1; e_pc_wdata = e.res[31:0];
      end else if (e.ctrl == 27) begin
        e_halted = 1; flush = 1;
      end else if (e.ctrl >= 28) begin
        e_err = 1;
      end
    end
    if (flush) mq.delete();
    else if (acc) mq.push_back({in_ctrl, in_dest, in_result});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] c, input logic [AW-1:0] d, input logic [63:0] r);
    in_valid = v; in_ctrl = c; in_dest = d; in_result = r;
  endtask

  task automatic do_reset();
    in_valid = 0;
    clr = 0;
    #1;
    model_reset();
    #6;
    clr = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 0;
    #2;
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    #5;
    clr = 1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(1, 5'd3, 4'd5, 64'h7);
    tick();
    drive(0, 5'd0, 4'd0, 64'h0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, hi, lo} !== {1'b1, 4'd5, 32'h7, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL add_retire: got we=%b a=%0d d=%h hi=%h lo=%h expected we=1 a=5 d=7 hi=0 lo=0",
               rf_we, rf_waddr, rf_wdata, hi, lo);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL add_strobe_width: got rf_we=%b vec=%h expected rf_we=0 vec=%h", rf_we, dut_vec, exp_vec);
    end
  endtask

  task automatic test_mul_mfhi_mflo();
    drive(1, 5'd15, 4'd0, 64'h0000_0001_8000_0000);
    tick();
    drive(1, 5'd24, 4'd2, 64'h0);
    tick();
    checks++;
    if ({hi, lo, rf_we} !== {32'h1, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL mul_hilo: got hi=%h lo=%h rf_we=%b expected hi=1 lo=80000000 rf_we=0", hi, lo, rf_we);
    end
    drive(1, 5'd25, 4'd3, 64'h0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd2, 32'h1}) begin
      errors++;
      $display("FAIL mfhi: got we=%b a=%0d d=%h expected we=1 a=2 d=1", rf_we, rf_waddr, rf_wdata);
    end
    drive(0, 5'd0, 4'd0, 64'h0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 32'h8000_0000} || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL mflo: got we=%b a=%0d d=%h expected we=1 a=3 d=80000000", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_mem_pc();
    drive(1, 5'd2, 4'd0, 64'h40);
    tick();
    drive(1, 5'd19, 4'd0, 64'h100);
    tick();
    checks++;
    if ({mem_req, mem_store, mem_addr, pc_we, rf_we} !== {1'b1, 1'b1, 32'h40, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL store: got req=%b st=%b addr=%h pc_we=%b rf_we=%b expected 1 1 40 0 0",
               mem_req, mem_store, mem_addr, pc_we, rf_we);
    end
    drive(0, 5'd0, 4'd0, 64'h0);
    tick();
    checks++;
    if ({pc_we, pc_wdata, mem_req, mem_addr} !== {1'b1, 32'h100, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL branch: got pc_we=%b pc=%h req=%b addr=%h expected 1 100 0 40",
               pc_we, pc_wdata, mem_req, mem_addr);
    end
  endtask

  task automatic test_throughput_halt();
    int accepted;
    int ready_low;
    accepted = 0;
    ready_low = 0;
    drive(1, 5'd26, 4'd0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      if (in_ready) accepted++;
      else ready_low++;
      tick();
    end
    checks++;
    if (accepted != 10 || ready_low != 0) begin
      errors++;
      $display("FAIL throughput: got accepted=%0d stalls=%0d expected 10 0", accepted, ready_low);
    end
    drive(1, 5'd27, 4'd0, 64'h0);
    tick();
    drive(1, 5'd3, 4'd9, 64'hDEAD);
    tick();
    checks++;
    if ({halted, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL halt: got halted=%b in_ready=%b expected 1 0", halted, in_ready);
    end
    drive(0, 5'd0, 4'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || halted !== 1'b1 || dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL halt_flush: got rf_we=%b halted=%b vec=%h expected 0 1 %h", rf_we, halted, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    drive(1, 5'd29, 4'd1, 64'h55);
    tick();
    drive(0, 5'd0, 4'd0, 64'h0);
    tick();
    checks++;
    if ({err, rf_we, pc_we, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL err_pulse: got err=%b rf_we=%b pc_we=%b mem_req=%b expected 1 0 0 0", err, rf_we, pc_we, mem_req);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: got err=%b expected 0", err);
    end
  endtask

  task automatic test_clr_mid();
    int seen_we;
    seen_we = 0;
    drive(1, 5'd15, 4'd0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    drive(1, 5'd3, 4'd7, 64'h1234);
    tick();
    drive(0, 5'd0, 4'd0, 64'h0);
    tick();
    checks++;
    if ({rf_wdata, hi} !== {32'h1234, 32'hAAAA_BBBB}) begin
      errors++;
      $display("FAIL clr_setup: got d=%h hi=%h expected 1234 aaaabbbb", rf_wdata, hi);
    end
    drive(1, 5'd3, 4'd1, 64'h11);
    tick();
    drive(1, 5'd3, 4'd2, 64'h22);
    #2;
    clr = 0;
    #1;
    if (rf_we) seen_we++;
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL clr_async: got %h expected 0", dut_vec);
    end
    in_valid = 0;
    #4;
    clr = 1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      if (rf_we) seen_we++;
      tick();
    end
    checks++;
    if (seen_we != 0) begin
      errors++;
      $display("FAIL clr_discard: got %0d rf writes expected 0", seen_we);
    end
  endtask

  task automatic test_random();
    int   halt_age;
    int   r;
    logic [4:0] c;
    halt_age = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (e_halted) begin
        halt_age++;
        if (halt_age > 2) begin
          do_reset();
          halt_age = 0;
        end
      end
      r = $urandom_range(0, 99);
      c = 5'($urandom_range(0, 31));
      if (c == 5'd27 && r >= 3) c = 5'd24;
      drive(($urandom_range(0, 3) != 0), c, AW'($urandom), {$urandom, $urandom});
      checks++;
      if (in_ready !== model_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, model_ready());
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    drive(0, 5'd0, 4'd0, 64'h0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_mul_mfhi_mflo();
    test_mem_pc();
    test_throughput_halt();
    test_err();
    test_clr_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
